mul_shift_ctrl: RTL and testbench

- Sequential shift-add controller for unsigned WIDTH x WIDTH multiplication.
- Drives the team's 65-bit universal shift register (product register) through its mode and data inputs, and reads back its Q output.
- Sits directly upstream of that register and owns the multiplicand and the iteration counter.
- The register's mode encoding is {S1,S0}: 00 hold, 01 shift right with SR entering the MSB, 10 shift left with SL entering the LSB, 11 parallel load D.

---
 rtl/mul_shift_ctrl_pkg.sv | 22 ++
 rtl/mul_shift_ctrl_if.sv | 28 ++
 rtl/mul_shift_ctrl.sv | 107 ++++++++++
 tb/tb_mul_shift_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_shift_ctrl_pkg.sv
// Shared constants for the shift-add multiply controller: shift register
// mode encoding, FSM state encoding and default widths.
package mul_shift_ctrl_pkg;

    localparam int WIDTH  = 32;
    localparam int PREG_W = 2 * WIDTH + 1;

    // Mode encoding is {S1,S0} of the universal shift register
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ADD,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mul_shift_ctrl_if.sv
// Request/result signals plus the product shift register control bus
// shared between the multiply controller and its environment.
interface mul_shift_ctrl_if #(
    parameter int WIDTH = mul_shift_ctrl_pkg::WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH:0]     q;
    logic                 s1;
    logic                 s0;
    logic                 sr;
    logic                 sl;
    logic [2*WIDTH:0]     d;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b, q,
        input  s1, s0, sr, sl, d, busy, done, product
    );

    modport slave (
        input  start, a, b, q,
        output s1, s0, sr, sl, d, busy, done, product
    );
endinterface

// File: rtl/mul_shift_ctrl.sv
// Shift-add multiply controller: sequences an external 2*WIDTH+1 bit
// universal shift register through load / conditional add / shift right.
module mul_shift_ctrl
    import mul_shift_ctrl_pkg::*;
#(
    parameter int WIDTH = mul_shift_ctrl_pkg::WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_shift_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH:0]     sum;
    logic [1:0]         mode;
    logic [2*WIDTH:0]   d_int;
    logic               busy_int;
    logic               done_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operands are latched on acceptance so the caller may change a/b freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                    end
                end
                ST_LOAD:  cnt <= '0;
                ST_SHIFT: begin
                    if (cnt != LAST_CNT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (bus.start) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_ADD;
            ST_ADD:   next_state = ST_SHIFT;
            ST_SHIFT: next_state = (cnt == LAST_CNT) ? ST_DONE : ST_ADD;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // The carry of the upper-half add lands in the register's top bit
    assign sum = {1'b0, bus.q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};

    always_comb begin
        mode     = MODE_HOLD;
        d_int    = '0;
        busy_int = 1'b1;
        done_int = 1'b0;
        case (state)
            ST_IDLE: busy_int = 1'b0;
            ST_LOAD: begin
                mode  = MODE_LOAD;
                d_int = {1'b0, {WIDTH{1'b0}}, b_q};
            end
            ST_ADD: begin
                if (bus.q[0]) begin
                    mode  = MODE_LOAD;
                    d_int = {sum, bus.q[WIDTH-1:0]};
                end
            end
            ST_SHIFT: mode = MODE_SHR;
            ST_DONE:  done_int = 1'b1;
            default:  busy_int = 1'b0;
        endcase
    end

    assign bus.s1      = mode[1];
    assign bus.s0      = mode[0];
    assign bus.sr      = 1'b0;
    assign bus.sl      = 1'b0;
    assign bus.d       = d_int;
    assign bus.busy    = busy_int;
    assign bus.done    = done_int;
    assign bus.product = bus.q[2*WIDTH-1:0];

endmodule

// File: tb/tb_mul_shift_ctrl.sv
// Self-checking bench for mul_shift_ctrl driving a behavioural 65-bit
// universal shift register; expected products flow through a scoreboard queue.
module tb_mul_shift_ctrl;
    import mul_shift_ctrl_pkg::*;

    localparam int W  = 32;
    localparam int PW = 2 * W + 1;
    localparam int LAT = 2 * W + 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mul_shift_ctrl_if #(.WIDTH(W)) bus ();

    mul_shift_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Product register: no reset, mode-driven like the real part
    logic [PW-1:0] preg;
    always_ff @(posedge clk) begin
        case ({bus.s1, bus.s0})
            MODE_SHR:  preg <= {bus.sr, preg[PW-1:1]};
            MODE_SHL:  preg <= {preg[PW-2:0], bus.sl};
            MODE_LOAD: preg <= bus.d;
            default:   ;
        endcase
    end
    assign bus.q = preg;

    int            checks = 0;
    int            errors = 0;
    int            load_cnt = 0;
    int            exp_loads = 0;
    bit            carry_seen = 1'b0;
    bit            shl_seen = 1'b0;
    bit            serial_bad = 1'b0;
    logic [2*W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n && bus.busy) begin
            if (bus.s1 && bus.s0) load_cnt++;
            if (bus.q[PW-1]) carry_seen = 1'b1;
        end
        if (bus.s1 && !bus.s0) shl_seen = 1'b1;
        if (bus.sr || bus.sl) serial_bad = 1'b1;
    end

    task automatic check_output(input string tag, input logic [PW-1:0] act,
                                input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input bit hold, input bit track);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        if (track) begin
            exp_q.push_back(64'(av) * 64'(bv));
            exp_loads  = 1 + $countones(bv);
            load_cnt   = 0;
            carry_seen = 1'b0;
        end
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    // Called just after the accepting edge; returns edges until done is seen
    task automatic wait_done(output int lat, output int gap);
        bit found = 1'b0;
        lat = 0;
        gap = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) begin
                found = 1'b1;
                break;
            end
            if (!bus.busy) gap++;
            @(posedge clk);
            lat++;
        end
        if (!found) check_output("done_timeout", PW'(0), PW'(1));
    endtask

    task automatic check_result(input string tag);
        logic [2*W-1:0] exp;
        if (exp_q.size() == 0) begin
            check_output({tag, "_no_expect"}, PW'(1), PW'(0));
        end else begin
            exp = exp_q.pop_front();
            check_output({tag, "_product"}, PW'(bus.product), PW'(exp));
            check_output({tag, "_carry"}, PW'(bus.q[PW-1]), PW'(0));
            check_output({tag, "_loads"}, PW'(load_cnt), PW'(exp_loads));
        end
    endtask

    int lat;
    int gap;

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check_output("rst_busy", PW'(bus.busy), PW'(0));
        check_output("rst_done", PW'(bus.done), PW'(0));
        check_output("rst_mode", PW'({bus.s1, bus.s0}), PW'(MODE_HOLD));
        check_output("rst_d", bus.d, PW'(0));
        rst_n = 1'b1;

        $display("[TB] 3 x 5");
        apply_stimulus(32'd3, 32'd5, 1'b0, 1'b1);
        wait_done(lat, gap);
        check_output("lat_3x5", PW'(lat), PW'(LAT));
        check_output("gap_3x5", PW'(gap), PW'(0));
        check_result("m3x5");

        $display("[TB] all ones");
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done(lat, gap);
        check_output("carry_seen", PW'(carry_seen), PW'(1));
        check_result("mffff");

        $display("[TB] zero operands");
        apply_stimulus(32'd0, 32'h1234_5678, 1'b0, 1'b1);
        wait_done(lat, gap);
        check_result("a0");
        apply_stimulus(32'h1234_5678, 32'd0, 1'b0, 1'b1);
        wait_done(lat, gap);
        check_output("lat_b0", PW'(lat), PW'(LAT));
        check_result("b0");

        $display("[TB] start held, operands changed mid-run");
        apply_stimulus(32'd7, 32'd9, 1'b1, 1'b1);
        bus.a = 32'd1;
        bus.b = 32'd1;
        wait_done(lat, gap);
        check_output("gap_held", PW'(gap), PW'(0));
        check_result("m7x9");
        @(negedge clk);
        check_output("idle_between", PW'(bus.busy), PW'(0));
        exp_q.push_back(64'd1);
        exp_loads  = 2;
        load_cnt   = 0;
        carry_seen = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check_output("restart_busy", PW'(bus.busy), PW'(1));
        wait_done(lat, gap);
        check_result("m1x1");

        $display("[TB] reset mid-operation");
        apply_stimulus(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_busy", PW'(bus.busy), PW'(0));
        check_output("midrst_done", PW'(bus.done), PW'(0));
        check_output("midrst_mode", PW'({bus.s1, bus.s0}), PW'(MODE_HOLD));
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(32'd2, 32'd2, 1'b0, 1'b1);
        wait_done(lat, gap);
        check_output("lat_2x2", PW'(lat), PW'(LAT));
        check_result("m2x2");

        $display("[TB] back-to-back");
        apply_stimulus(32'd10, 32'd10, 1'b0, 1'b1);
        wait_done(lat, gap);
        check_result("m10x10");
        apply_stimulus(32'd6, 32'd7, 1'b0, 1'b1);
        check_output("hold_100", PW'(bus.product), PW'(100));
        wait_done(lat, gap);
        check_output("lat_6x7", PW'(lat), PW'(LAT));
        check_result("m6x7");

        check_output("no_shl", PW'(shl_seen), PW'(0));
        check_output("serial_zero", PW'(serial_bad), PW'(0));
        check_output("queue_empty", PW'(exp_q.size()), PW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
